pattern_game_core: RTL and testbench

//  Parametrised memory-game engine: N_CH buttons/LEDs, configurable pattern depth, round count and timing.

---
 rtl/pattern_game_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_pattern_game_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_game_core.sv
// pattern_game_core: memory-game engine. Each round the LFSR adds one symbol to the
// pattern. The pattern is played back on the LEDs, then the player's button replay is
// checked. A wrong press or a timeout loses the game; N_ROUNDS completed rounds win it.
module pattern_game_core #(
  parameter int          N_CH          = 8,
  parameter int          MAX_LEN       = 16,
  parameter int          N_ROUNDS      = 10,
  parameter int          SHOW_TICKS    = 4,
  parameter int          GAP_TICKS     = 2,
  parameter int          TIMEOUT_TICKS = 50,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         LW            = $clog2(MAX_LEN + 1),
  localparam int         RW            = $clog2(N_ROUNDS + 1)
) (
  input  logic            clk_2,
  input  logic            rst,
  input  logic            tick,
  input  logic            start,
  input  logic            abort,
  input  logic [LW-1:0]   len_init,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] led,
  output logic [RW-1:0]   round_no,
  output logic [LW-1:0]   cur_len,
  output logic [15:0]     score,
  output logic            busy,
  output logic            win,
  output logic            lose
);

  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (TIMEOUT_TICKS > SHOW_TICKS) ?
                        ((TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS) :
                        ((SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS);
  localparam int TW   = $clog2(TMAX + 1);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0]     SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [LW-1:0]   MAX_LEN_C = LW'(MAX_LEN);
  localparam logic [RW-1:0]   ROUNDS_C  = RW'(N_ROUNDS);
  localparam logic [TW-1:0]   SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0]   GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [N_CH-1:0] ONE       = N_CH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [LW-1:0]   cur_len_q, cur_len_d;
  logic [LW-1:0]   target_q, target_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [RW-1:0]   round_q, round_d;
  logic [15:0]     score_q, score_d;
  logic [N_CH-1:0] led_q, led_d;
  logic            busy_q, busy_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;

  logic [SW-1:0]   pat_mem [MAX_LEN];

  logic [15:0]     lfsr_next;
  logic [SW-1:0]   sym_raw, sym_new, rd_sym;
  logic [IW-1:0]   wr_idx;
  logic            gen_we;
  logic [LW-1:0]   start_len;
  logic [N_CH-1:0] exp_btn;
  logic            last_idx;
  logic [16:0]     score_sum;
  logic [15:0]     score_sat;

  // Next LFSR value and the symbol it yields, folded into 0..N_CH-1.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign sym_raw   = lfsr_next[SW-1:0];
  assign sym_new   = (32'(sym_raw) >= 32'(N_CH)) ? (sym_raw - SW'(N_CH)) : sym_raw;
  assign wr_idx    = cur_len_q[IW-1:0];

  // Difficulty clamped to 1..MAX_LEN at game start.
  assign start_len = (len_init == '0)       ? LW'(1)    :
                     (len_init > MAX_LEN_C) ? MAX_LEN_C : len_init;

  assign exp_btn   = ONE << pat_mem[idx_q];
  assign last_idx  = (LW'(idx_q) + LW'(1)) == cur_len_q;
  assign score_sum = {1'b0, score_q} + 17'(cur_len_q);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Pattern storage: one symbol written per GEN cycle.
  // NOTE: the pattern RAM has no reset; its content is only read after GEN has written it.
  always_ff @(posedge clk_2) begin
    if (gen_we) pat_mem[wr_idx] <= sym_new;
  end

  // Game FSM: next state, LFSR, counters and score.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cur_len_d = cur_len_q;
    target_d  = target_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    round_d   = round_q;
    score_d   = score_q;
    gen_we    = 1'b0;

    if (abort) begin
      // Abort wins over start and leaves counters untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state_d   = S_GEN;
            cur_len_d = '0;
            target_d  = start_len;
            round_d   = '0;
            score_d   = '0;
            idx_d     = '0;
            tmr_d     = '0;
          end
        end

        S_GEN: begin
          gen_we    = 1'b1;
          lfsr_d    = lfsr_next;
          cur_len_d = cur_len_q + LW'(1);
          if (cur_len_q + LW'(1) == target_q) begin
            state_d = S_SHOW_ON;
            idx_d   = '0;
            tmr_d   = '0;
          end
        end

        S_SHOW_ON: begin
          if (tick) begin
            if (tmr_q == SHOW_LAST) begin
              state_d = S_SHOW_OFF;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
        end

        S_SHOW_OFF: begin
          if (tick) begin
            if (tmr_q == GAP_LAST) begin
              tmr_d = '0;
              if (last_idx) begin
                state_d = S_WAIT_IN;
                idx_d   = '0;
              end else begin
                state_d = S_SHOW_ON;
                idx_d   = idx_q + IW'(1);
              end
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
        end

        S_WAIT_IN: begin
          if (btn != '0) begin
            // A press outranks a timeout tick in the same cycle.
            if (btn == exp_btn) begin
              tmr_d = '0;
              if (last_idx) begin
                score_d = score_sat;
                round_d = round_q + RW'(1);
                idx_d   = '0;
                if (round_q + RW'(1) == ROUNDS_C) begin
                  state_d = S_WIN;
                end else if (cur_len_q == MAX_LEN_C) begin
                  state_d = S_SHOW_ON;
                end else begin
                  state_d  = S_GEN;
                  target_d = cur_len_q + LW'(1);
                end
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end else begin
              state_d = S_LOSE;
            end
          end else if (tick) begin
            if (tmr_q == TO_LAST) state_d = S_LOSE;
            else                  tmr_d   = tmr_q + TW'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs derived from the next state; the RAM read bypasses a same-cycle write.
  always_comb begin
    rd_sym = (gen_we && (wr_idx == idx_d)) ? sym_new : pat_mem[idx_d];
    case (state_d)
      S_SHOW_ON: led_d = ONE << rd_sym;
      S_WIN:     led_d = '1;
      default:   led_d = '0;
    endcase
    busy_d = (state_d == S_GEN) || (state_d == S_SHOW_ON) ||
             (state_d == S_SHOW_OFF) || (state_d == S_WAIT_IN);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // State and output registers with asynchronous reset.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      cur_len_q <= '0;
      target_q  <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      round_q   <= '0;
      score_q   <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cur_len_q <= cur_len_d;
      target_q  <= target_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      round_q   <= round_d;
      score_q   <= score_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  assign led      = led_q;
  assign round_no = round_q;
  assign cur_len  = cur_len_q;
  assign score    = score_q;
  assign busy     = busy_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_pattern_game_core.sv
// tb_pattern_game_core: scoreboard bench for pattern_game_core. A reference LFSR model
// predicts each pattern; expected LED symbols are queued when a game or round starts
// and popped by a monitor as the DUT lights them.
module tb_pattern_game_core;

  localparam int          N_CH          = 8;
  localparam int          MAX_LEN       = 16;
  localparam int          N_ROUNDS      = 2;
  localparam int          SHOW_TICKS    = 2;
  localparam int          GAP_TICKS     = 1;
  localparam int          TIMEOUT_TICKS = 5;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int          LW            = $clog2(MAX_LEN + 1);
  localparam int          RW            = $clog2(N_ROUNDS + 1);

  logic            clk_2 = 1'b0;
  logic            rst   = 1'b0;
  logic            tick  = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [LW-1:0]   len_init = '0;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] led;
  logic [RW-1:0]   round_no;
  logic [LW-1:0]   cur_len;
  logic [15:0]     score;
  logic            busy, win, lose;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  int          lit_cnt  = 0;
  int          lit_goal = 0;
  logic [15:0] m_lfsr   = SEED;
  logic [2:0]  mpat [MAX_LEN];
  int          mlen     = 0;

  pattern_game_core #(
    .N_CH(N_CH), .MAX_LEN(MAX_LEN), .N_ROUNDS(N_ROUNDS), .SHOW_TICKS(SHOW_TICKS),
    .GAP_TICKS(GAP_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .SEED(SEED)
  ) dut (
    .clk_2(clk_2), .rst(rst), .tick(tick), .start(start), .abort(abort),
    .len_init(len_init), .btn(btn), .led(led), .round_no(round_no),
    .cur_len(cur_len), .score(score), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk_2 = ~clk_2;

  // Time base: one-cycle tick every 4 clocks.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk_2);
      #1;
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] s);
    return 8'(1) << s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Grow the model pattern to tgt symbols and queue the full playback.
  task automatic model_gen(input int tgt);
    int s;
    while (mlen < tgt) begin
      m_lfsr = lfsr_step(m_lfsr);
      s = int'(m_lfsr[2:0]);
      if (s >= N_CH) s = s - N_CH;
      mpat[mlen] = 3'(s);
      mlen++;
    end
    for (int i = 0; i < mlen; i++) exp_q.push_back(oh(mpat[i]));
    lit_goal = lit_cnt + mlen;
  endtask

  task automatic model_next_round();
    model_gen((mlen + 1 > MAX_LEN) ? MAX_LEN : mlen + 1);
  endtask

  // Playback monitor: checks each lit symbol and how many ticks it stays lit.
  initial begin
    logic [7:0] prev;
    logic [7:0] e;
    int         lt;
    prev = '0;
    lt   = 0;
    forever begin
      @(negedge clk_2);
      if (busy && led != '0 && prev == '0) begin
        lit_cnt++;
        lt = 0;
        if (exp_q.size() == 0) check("led_unexpected", led, 0);
        else begin
          e = exp_q.pop_front();
          check("led_sym", led, e);
        end
      end
      if (busy && led != '0 && tick) lt++;
      if (busy && led == '0 && prev != '0) check("lit_ticks", lt, SHOW_TICKS);
      prev = busy ? led : '0;
    end
  end

  task automatic press(input logic [7:0] b);
    btn = b;
    @(posedge clk_2);
    #1;
    btn = '0;
  endtask

  task automatic start_game(input int len);
    int n, tgt;
    tgt  = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
    mlen = 0;
    model_gen(tgt);
    len_init = LW'(len);
    start = 1'b1;
    @(posedge clk_2);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (led == '0 && n < 200) begin
      @(posedge clk_2);
      #1;
      n++;
    end
    check("gen_cycles", n, tgt);
    check("cur_len_at_show", cur_len, tgt);
  endtask

  // Returns just after the edge that moves the DUT into WAIT_IN.
  task automatic wait_wait_in();
    int budget;
    budget = 3000;
    while (lit_cnt < lit_goal && budget > 0) begin @(negedge clk_2); #1; budget--; end
    while (led != '0 && budget > 0)          begin @(negedge clk_2); #1; budget--; end
    while (!tick && budget > 0)              begin @(negedge clk_2); #1; budget--; end
    @(posedge clk_2);
    #1;
    check("wait_in_budget", (budget > 0), 1);
  endtask

  // Returns mid-cycle in the cycle carrying the n-th tick (not yet sampled).
  task automatic wait_ticks(input int n);
    int seen, budget;
    seen = 0;
    budget = 500;
    while (seen < n && budget > 0) begin
      @(negedge clk_2);
      #1;
      budget--;
      if (tick) seen++;
    end
    check("tick_budget", (budget > 0), 1);
  endtask

  task automatic replay(input bit next_round);
    int L;
    logic [2:0] s;
    L = mlen;
    for (int i = 0; i < L; i++) begin
      s = mpat[i];
      if (i == L - 1 && next_round) model_next_round();
      press(oh(s));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},   led,      0);
    check({tag, "_round"}, round_no, 0);
    check({tag, "_len"},   cur_len,  0);
    check({tag, "_score"}, score,    0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_win"},   win,      0);
    check({tag, "_lose"},  lose,     0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [2:0] s0, s1;

    // Reset asserted between clock edges takes effect immediately.
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk_2);
    #1 rst = 1'b0;

    // Two full rounds from len 3 to a win.
    start_game(3);
    wait_wait_in();
    replay(1'b1);
    check("r1_score", score, 3);
    check("r1_round", round_no, 1);
    check("r1_lose", lose, 0);
    wait_wait_in();
    check("r2_cur_len", cur_len, 4);
    replay(1'b0);
    check("win_flag", win, 1);
    check("win_led", led, 8'hFF);
    check("win_score", score, 7);
    check("win_round", round_no, 2);
    check("win_busy", busy, 0);

    // Wrong second press.
    start_game(3);
    wait_wait_in();
    press(oh(mpat[0]));
    check("alive_after_first", lose, 0);
    press(oh(mpat[1] + 3'd1));
    check("wrong_lose", lose, 1);
    check("wrong_led", led, 0);
    check("wrong_score", score, 0);
    check("wrong_busy", busy, 0);

    // Two buttons at once.
    start_game(3);
    wait_wait_in();
    press(oh(mpat[0]) | oh(mpat[0] + 3'd4));
    check("multi_lose", lose, 1);
    check("multi_score", score, 0);

    // len_init=0 plays one symbol; no press for 5 ticks loses.
    start_game(0);
    wait_wait_in();
    wait_ticks(5);
    check("alive_before_timeout", lose, 0);
    @(posedge clk_2);
    #1;
    check("timeout_lose", lose, 1);

    // Press on the 5th tick survives and clears the timer.
    start_game(2);
    wait_wait_in();
    s0 = mpat[0];
    s1 = mpat[1];
    wait_ticks(5);
    btn = oh(s0);
    @(posedge clk_2);
    #1;
    btn = '0;
    check("press_on_5th_alive", lose, 0);
    wait_ticks(4);
    @(posedge clk_2);
    #1;
    check("timer_cleared", lose, 0);
    base = lit_cnt;
    model_next_round();
    press(oh(s1));
    check("tb_round", round_no, 1);
    check("tb_score", score, 2);

    // Abort during SHOW_ON.
    begin
      int budget;
      budget = 500;
      while (lit_cnt == base && budget > 0) begin @(negedge clk_2); #1; budget--; end
      check("show_after_round", (lit_cnt > base), 1);
    end
    abort = 1'b1;
    @(posedge clk_2);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_led", led, 0);
    check("abort_busy", busy, 0);
    check("abort_win", win, 0);
    check("abort_lose", lose, 0);
    check("abort_score", score, 2);
    check("abort_round", round_no, 1);
    check("abort_len", cur_len, 3);

    // len_init=20 clamps to 16; reset mid-playback.
    base = lit_cnt;
    start_game(20);
    begin
      int budget;
      budget = 2000;
      while (lit_cnt < base + 2 && budget > 0) begin @(negedge clk_2); #1; budget--; end
      check("long_show_lit", (led != '0), 1);
    end
    rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk_2);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_lfsr = SEED;
    mlen   = 0;

    // After reset the LFSR restarts from the seed.
    start_game(0);
    wait_wait_in();
    replay(1'b1);
    check("post_rst_round", round_no, 1);
    check("post_rst_score", score, 1);
    wait_wait_in();
    check("post_rst_len", cur_len, 2);
    replay(1'b0);
    check("post_rst_win", win, 1);
    check("post_rst_score2", score, 3);

    repeat (4) @(posedge clk_2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
